// File: rtl/serial_number_feeder.sv
// ----------------------------------------------------------------------------
// serial_number_feeder
//
// Front end for the serial divisibility checkers (by-3 / by-5). It accepts
// W-bit numbers over a valid/ready handshake. Each number is preceded by a
// one-cycle clear pulse, which restarts the checker's remainder at 0. The
// number is then emitted one bit per cycle, MSB first by default.
//
// Parameters
//   W          number width in bits (W >= 2)
//   MSB_FIRST  1: emit in_data[W-1] first; 0: emit in_data[0] first
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data holds a number to send
//   in_ready   feeder accepts in_data this cycle (independent of in_valid)
//   in_data    number to serialise
//   out_clear  1-cycle pulse ahead of the first bit; drives the checker rst
//   out_valid  out_bit carries a number bit this cycle
//   out_bit    current bit; drives the checker new_bit
//   out_last   out_bit is the final bit of the number
//   busy       feeder is not idle
//
// The checker has no enable, so it also absorbs the zeros driven while idle.
// Its result is only meaningful in the cycle after out_valid && out_last.
// ----------------------------------------------------------------------------
module serial_number_feeder #(
    parameter int unsigned W         = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_clear,
    output logic         out_valid,
    output logic         out_bit,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  shreg;
    logic [W-1:0]  shreg_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          at_last;
    logic          xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        out_clear = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;

        at_last  = (state == SHIFT) && (cnt == CNT_LAST);
        // A new word may be taken on the last bit of the current one.
        // This allows back-to-back numbers with a period of W+1 cycles.
        in_ready = !rst && ((state == IDLE) || at_last);
        xfer     = in_valid && in_ready;
        busy     = (state != IDLE);

        case (state)
            IDLE: begin
                if (xfer) begin
                    shreg_nxt = in_data;
                    cnt_nxt   = '0;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                out_clear = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_bit   = MSB_FIRST ? shreg[W-1] : shreg[0];
                out_last  = at_last;
                shreg_nxt = MSB_FIRST ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};
                cnt_nxt   = cnt + 1'b1;
                if (at_last) begin
                    // Clear the counter explicitly. When W is not a power of
                    // two, cnt+1 would otherwise step past W-1.
                    cnt_nxt = '0;
                    if (xfer) begin
                        shreg_nxt = in_data;
                        state_nxt = CLEAR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
